alu_operand_collector: RTL
==========================

# alu_operand_collector

Bus-side reader that feeds the 8-bit adder. Captures operand bytes from the main bus into Lhs/Rhs holding registers and tracks which operands are present with a 4-state FSM. Presents a complete operand pair plus carry select to the adder under a valid/ready handshake. Updates the carry and zero flag registers from the adder's combinational result on the same edge the pair is consumed; the carry flag drives the adder's carryIn.

## Interface
- No parameters. Data width is fixed at 8; it is the shared `ALU_WIDTH` constant.
- `clk` in 1: single clock, rising edge.
- `nReset` in 1: synchronous, active-low reset.
- `mainBusIn` in 8: main bus value.
- `loadLhs` in 1: capture `mainBusIn` as the left operand.
- `loadRhs` in 1: capture `mainBusIn` as the right operand.
- `carrySelIn` in 2: carry select, captured together with the Lhs load. Encoding: 0 → 0, 1 → 1, 2 → carry flag, 3 → 0.
- `flush` in 1: discard held operands.
- `opReady` in 1: downstream accepts the operand pair.
- `adderResult` in 8: adder sum for the presented pair.
- `adderCarryOut` in 1: adder carry for the presented pair.
- `Lhs` out 8, `Rhs` out 8, `CarrySelect` out 2: registered operands to the adder.
- `opValid` out 1: a complete pair is presented.
- `carryFlag` out 1: registered carry; wired to the adder's carryIn.
- `zeroFlag` out 1: registered zero flag.
- `loadDropped` out 1: sticky error flag.

## Operation
- FSM states: EMPTY, HAVE_LHS, HAVE_RHS, FULL. `opValid` = (state == FULL), decoded from registered state.
- `fire` = `opValid && opReady`.
- Load acceptance: a load is accepted when its slot is empty or `fire` is high in the same cycle. Accepted loads write `mainBusIn` into the slot; `loadLhs` also writes `carrySelIn` into `CarrySelect`.
- Simultaneous `loadLhs` + `loadRhs`: both slots take the same bus byte.
- Next state, from slot occupancy after the edge:
  - Lhs occupied = (Lhs held && !fire) || accepted `loadLhs`.
  - Rhs occupied is computed the same way.
  - Occupancy maps to EMPTY / HAVE_LHS / HAVE_RHS / FULL.
- On `fire`:
  - `carryFlag` ← `adderCarryOut`.
  - `zeroFlag` ← (`adderResult` == 0).
  - Flags are sampled from the adder's combinational outputs for the pair currently presented. Loads in the same cycle cannot corrupt them, because the operand registers change only at the edge.
- Load into an occupied slot with no `fire` that cycle: the load is ignored, the held value is unchanged, and `loadDropped` sets. `loadDropped` clears only on reset.
- `flush`:
  - Next state is EMPTY, overriding loads and `fire` in the same cycle.
  - Operand register contents are don't-care.
  - Flags still update if `fire` is high in the same cycle.
- Arithmetic: none performed here. The zero test is an 8-bit compare. `carryFlag` is never modified except on `fire` or reset.
- Reset values (`nReset` low at a rising edge):
  - state EMPTY, `opValid` 0.
  - `Lhs` 0, `Rhs` 0, `CarrySelect` 0.
  - `carryFlag` 0, `zeroFlag` 0, `loadDropped` 0.
- Reset has priority over every input, including a mid-handshake `fire`. On that edge no flag update happens and no load is accepted.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Load-to-valid latency: 1 cycle after the edge that completes the pair. For both operands loaded in cycle N, `opValid` is high in cycle N+1.
- Back-to-back operation: `fire` plus both loads in cycle N gives a new pair, `opValid` high, in cycle N+1. Sustained throughput is one operation per cycle.
- `opValid` stays high and the operands are stable until `fire`. `opReady` may be held low indefinitely.
- Flags become visible the cycle after `fire`. A pair fired in cycle N+1 using CarrySelect = 2 sees the carry produced by a `fire` in cycle N.

## Structure
- The shared package `alu_pkg` holds:
  - `ALU_WIDTH` = 8.
  - The carry-select encodings `CARRY_ZERO` = 0, `CARRY_ONE` = 1, `CARRY_FLAG` = 2.
  - The FSM state enum.
- The flag logic is a natural sub-module, `alu_flag_reg`:
  - Inputs: `fire`, `adderResult`, `adderCarryOut`, reset.
  - Outputs: `carryFlag`, `zeroFlag`.
  - It is reused later by the subtract/logic units.
- The rest (FSM and operand registers) is flat in the top module.

## Test plan
- Reset then load: `loadLhs` with bus 0x12 and `carrySelIn` 1, then `loadRhs` with bus 0x34.
  - `opValid` is high one cycle after the second load; Lhs = 0x12, Rhs = 0x34, CarrySelect = 1.
  - The model adder gives 0x47; `fire` leaves carryFlag 0 and zeroFlag 0.
- Carry chain: fire 0xFF + 0x01 with select 0, giving result 0x00.
  - carryFlag = 1 and zeroFlag = 1.
  - A next pair 0x00 + 0x00 with select 2 presents CarrySelect = 2, and the adder sees carryIn = 1.
- Overrun: with the collector FULL and `opReady` 0, pulse `loadRhs` with bus 0xAA.
  - Rhs is unchanged and `loadDropped` goes to 1 and stays 1.
  - A following `fire` still uses the original Rhs.
- Streaming: hold `opReady` 1 and drive `loadLhs` + `loadRhs` every cycle with the bus incrementing from 0x00.
  - `opValid` stays continuously high from cycle 2.
  - Each fired pair is (n, n), with no drops.
- Flush and reset priority:
  - In HAVE_LHS, assert `flush` together with `loadRhs`: the state returns to EMPTY and `opValid` stays 0.
  - While FULL, assert `nReset` low in the same cycle as `fire` with carryOut 1: carryFlag stays 0 and all outputs take their reset values.

Source files
------------

// File: rtl/alu_operand_collector_pkg.sv
// Shared ALU definitions: datapath width, carry-select encodings and the
// operand-collector state type used by the adder front end.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [1:0] CARRY_ZERO = 2'd0;
  localparam logic [1:0] CARRY_ONE  = 2'd1;
  localparam logic [1:0] CARRY_FLAG = 2'd2;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    HAVE_LHS = 2'd1,
    HAVE_RHS = 2'd2,
    FULL     = 2'd3
  } collector_state_t;

endpackage

// File: rtl/alu_operand_collector_if.sv
// Bus, handshake and adder-side signals of the operand collector.
// The master side drives the bus and the adder result; the slave side is the collector.
interface alu_operand_collector_if;

  logic [alu_pkg::ALU_WIDTH-1:0] mainBusIn;
  logic                          loadLhs;
  logic                          loadRhs;
  logic [1:0]                    carrySelIn;
  logic                          flush;
  logic                          opReady;
  logic [alu_pkg::ALU_WIDTH-1:0] adderResult;
  logic                          adderCarryOut;
  logic [alu_pkg::ALU_WIDTH-1:0] Lhs;
  logic [alu_pkg::ALU_WIDTH-1:0] Rhs;
  logic [1:0]                    CarrySelect;
  logic                          opValid;
  logic                          carryFlag;
  logic                          zeroFlag;
  logic                          loadDropped;

  modport master (
    output mainBusIn, loadLhs, loadRhs, carrySelIn, flush, opReady,
           adderResult, adderCarryOut,
    input  Lhs, Rhs, CarrySelect, opValid, carryFlag, zeroFlag, loadDropped
  );

  modport slave (
    input  mainBusIn, loadLhs, loadRhs, carrySelIn, flush, opReady,
           adderResult, adderCarryOut,
    output Lhs, Rhs, CarrySelect, opValid, carryFlag, zeroFlag, loadDropped
  );

endinterface

// File: rtl/alu_flag_reg.sv
// Carry and zero flag registers, loaded from the adder's combinational
// result whenever an operand pair is consumed.
module alu_flag_reg
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 fire,
  input  logic [ALU_WIDTH-1:0] adderResult,
  input  logic                 adderCarryOut,
  output logic                 carryFlag,
  output logic                 zeroFlag
);

  always_ff @(posedge clk) begin
    if (!nReset) begin
      carryFlag <= 1'b0;
      zeroFlag  <= 1'b0;
    end else if (fire) begin
      carryFlag <= adderCarryOut;
      zeroFlag  <= (adderResult == '0);
    end
  end

endmodule

// File: rtl/alu_operand_collector.sv
// Collects Lhs/Rhs operand bytes from the main bus and presents complete
// pairs to the adder under a valid/ready handshake.
module alu_operand_collector
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  nReset,
  alu_operand_collector_if.slave bus
);

  collector_state_t     state;
  collector_state_t     stateNext;
  logic                 lhsHeld;
  logic                 rhsHeld;
  logic                 fire;
  logic                 acceptLhs;
  logic                 acceptRhs;
  logic                 lhsOccupied;
  logic                 rhsOccupied;
  logic                 dropNow;
  logic [ALU_WIDTH-1:0] lhsReg;
  logic [ALU_WIDTH-1:0] rhsReg;
  logic [1:0]           selReg;
  logic                 droppedReg;
  logic                 carryFlag;
  logic                 zeroFlag;

  assign lhsHeld = (state == HAVE_LHS) || (state == FULL);
  assign rhsHeld = (state == HAVE_RHS) || (state == FULL);
  assign fire    = (state == FULL) && bus.opReady;

  // A slot being drained by this cycle's fire can be refilled on the same edge.
  assign acceptLhs   = bus.loadLhs && (!lhsHeld || fire);
  assign acceptRhs   = bus.loadRhs && (!rhsHeld || fire);
  assign lhsOccupied = (lhsHeld && !fire) || acceptLhs;
  assign rhsOccupied = (rhsHeld && !fire) || acceptRhs;
  assign dropNow     = (bus.loadLhs && !acceptLhs) || (bus.loadRhs && !acceptRhs);

  always_comb begin
    stateNext = state;
    case ({lhsOccupied, rhsOccupied})
      2'b00: stateNext = EMPTY;
      2'b10: stateNext = HAVE_LHS;
      2'b01: stateNext = HAVE_RHS;
      2'b11: stateNext = FULL;
    endcase
    if (bus.flush) begin
      stateNext = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state      <= EMPTY;
      lhsReg     <= '0;
      rhsReg     <= '0;
      selReg     <= CARRY_ZERO;
      droppedReg <= 1'b0;
    end else begin
      state <= stateNext;
      if (acceptLhs) begin
        lhsReg <= bus.mainBusIn;
        selReg <= bus.carrySelIn;
      end
      if (acceptRhs) begin
        rhsReg <= bus.mainBusIn;
      end
      if (dropNow) begin
        droppedReg <= 1'b1;
      end
    end
  end

  alu_flag_reg flagReg (
    .clk          (clk),
    .nReset       (nReset),
    .fire         (fire),
    .adderResult  (bus.adderResult),
    .adderCarryOut(bus.adderCarryOut),
    .carryFlag    (carryFlag),
    .zeroFlag     (zeroFlag)
  );

  assign bus.Lhs         = lhsReg;
  assign bus.Rhs         = rhsReg;
  assign bus.CarrySelect = selReg;
  assign bus.opValid     = (state == FULL);
  assign bus.carryFlag   = carryFlag;
  assign bus.zeroFlag    = zeroFlag;
  assign bus.loadDropped = droppedReg;

endmodule
